// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU port.
// It serves one request at a time from a word-addressed RAM and two I/O
// registers, and adds a fixed number of wait cycles before each response.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   reset    asynchronous, active-low reset
//   req      request valid; held with addr/we/wdata until ready
//   we       1 = write, 0 = read
//   addr     byte address
//   wdata    write data
//   ready    one-cycle completion pulse
//   rdata    read data, valid with ready, held until the next read response
//   err      error flag, valid with ready
//   sw_in    raw board switches (asynchronous)
//   led_out  LED register
//
// state | meaning
// IDLE  | waiting for req; request captured on the accepting edge
// WAIT  | counting wait cycles for an accepted, well-formed request
// RESP  | ready high for this one cycle; writes commit on the edge leaving it

module mem_responder #(
    parameter int          ADDR_W   = 9,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] LED_ADDR = 32'h0000_FF00,
    parameter logic [31:0] SW_ADDR  = 32'h0000_FF04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    input  logic [7:0]  sw_in,
    output logic [7:0]  led_out
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [3:0]  LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    // RAM is deliberately not reset; contents survive a reset.
    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    // Decode is shared: in IDLE it looks at the live bus (accept decision and
    // the zero-latency read), afterwards at the captured request.
    logic [31:0]       lk_addr;
    logic              lk_is_led;
    logic              lk_is_sw;
    logic              lk_in_range;
    logic              lk_err;
    logic [ADDR_W-1:0] lk_idx;
    logic [31:0]       lk_rdata;

    always_comb begin
        lk_addr     = (state == ST_IDLE) ? addr : cap_addr;
        lk_is_led   = (lk_addr == LED_ADDR);
        lk_is_sw    = (lk_addr == SW_ADDR);
        lk_in_range = ((lk_addr >> (ADDR_W + 2)) == 32'd0);
        lk_err      = (lk_addr[1:0] != 2'b00) || !(lk_is_led || lk_is_sw || lk_in_range);
        lk_idx      = lk_addr[ADDR_W+1:2];
        if (lk_err) begin
            lk_rdata = ERR_DATA;
        end else if (lk_is_led) begin
            lk_rdata = {24'b0, led_out};
        end else if (lk_is_sw) begin
            lk_rdata = {24'b0, sw_sync};
        end else begin
            lk_rdata = mem[lk_idx];
        end
    end

    assign ready = (state == ST_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= 8'd0;
            sw_sync <= 8'd0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_we    <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            led_out   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_addr  <= addr;
                        cap_we    <= we;
                        cap_wdata <= wdata;
                        wait_cnt  <= 4'd0;
                        // Errors skip the wait cycles entirely.
                        if (lk_err || LATENCY == 0) begin
                            state <= ST_RESP;
                            err   <= lk_err;
                            if (!we) begin
                                rdata <= lk_rdata;
                            end
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= ST_RESP;
                        err      <= lk_err;
                        if (!cap_we) begin
                            rdata <= lk_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (cap_we && !lk_err && lk_is_led) begin
                        led_out <= cap_wdata[7:0];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Commit happens on the edge leaving RESP; a reset in RESP drops the
    // state to IDLE first, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && cap_we && !lk_err && !lk_is_led && !lk_is_sw) begin
            mem[lk_idx] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int          LAT       = 2;
    localparam logic [31:0] LED_A     = 32'h0000_FF00;
    localparam logic [31:0] SW_A      = 32'h0000_FF04;
    localparam longint      RAM_BYTES = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [7:0]  sw_in = 8'd0;
    logic        ready, err;
    logic [31:0] rdata;
    logic [7:0]  led_out;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
    logic        ready0, err0;
    logic [31:0] rdata0;
    logic [7:0]  led_out0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .err(err), .sw_in(sw_in), .led_out(led_out)
    );

    mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .rdata(rdata0), .err(err0), .sw_in(sw_in), .led_out(led_out0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a != LED_A && a != SW_A && longint'(a) >= RAM_BYTES);
    endfunction

    // ---------------- transaction-level reference model (LATENCY=2 DUT) ----
    int unsigned e_cnt = 0, m_resp = 0, next_free = 0;
    bit          m_busy, m_we, m_err, m_led_hit, m_sw_hit;
    logic [31:0] m_addr, m_wdata;
    bit [31:0]   m_mem [512];
    bit [7:0]    m_led, m_sw1, m_sw2, sw_now;
    bit          exp_ready, exp_err, exp_rdv;
    logic [31:0] exp_rdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_led = 0; m_sw1 = 0; m_sw2 = 0;
            exp_ready = 0; exp_rdv = 0; next_free = 0;
        end else begin
            e_cnt++;
            exp_ready = 0;
            exp_rdv = 0;
            sw_now = m_sw2;
            if (m_busy && e_cnt == m_resp + 1) begin
                if (m_we && !m_err) begin
                    if (m_led_hit) m_led = m_wdata[7:0];
                    else if (!m_sw_hit) m_mem[int'((m_addr % 2048) / 4)] = m_wdata;
                end
                m_busy = 0;
            end
            if (!m_busy && req && e_cnt >= next_free) begin
                m_addr = addr; m_we = we; m_wdata = wdata;
                m_led_hit = (addr == LED_A);
                m_sw_hit = (addr == SW_A);
                m_err = addr_err(addr);
                m_resp = e_cnt + (m_err ? 0 : LAT);
                next_free = m_resp + 2;
                m_busy = 1;
            end
            if (m_busy && e_cnt == m_resp) begin
                exp_ready = 1;
                exp_err = m_err;
                if (!m_we) begin
                    exp_rdv = 1;
                    if (m_err) exp_rdata = 32'hDEAD_BEEF;
                    else if (m_led_hit) exp_rdata = {24'b0, m_led};
                    else if (m_sw_hit) exp_rdata = {24'b0, sw_now};
                    else exp_rdata = m_mem[int'((m_addr % 2048) / 4)];
                end
            end
            m_sw2 = m_sw1;
            m_sw1 = sw_in;
        end
    end

    bit          hold_chk = 0;
    logic [31:0] held;

    always @(negedge clk) begin
        if (reset) begin
            chk("ready", 32'(ready), 32'(exp_ready));
            if (exp_ready) chk("err", 32'(err), 32'(exp_err));
            if (exp_rdv) chk("rdata", rdata, exp_rdata);
            if (hold_chk && !exp_ready) chk("rdata_hold", rdata, held);
            hold_chk = exp_rdv;
            held = exp_rdata;
            chk("led_out", 32'(led_out), 32'(m_led));
        end else begin
            hold_chk = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready(input bit sel, output int cyc);
        bit rdy;
        cyc = 0;
        rdy = 0;
        while (!rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
            rdy = sel ? ready0 : ready;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL timeout: no ready after %0d cycles (dut sel=%0d)", cyc, sel);
        end
    endtask

    task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, output int cyc, output logic [31:0] rd, output bit er);
        if (sel) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        else     begin req = 1;  we = w;  addr = a;  wdata = d;  end
        wait_ready(sel, cyc);
        rd = sel ? rdata0 : rdata;
        er = sel ? err0 : err;
        if (!hold) begin
            if (sel) req0 = 0; else req = 0;
        end
    endtask

    bit [31:0] mem0 [512];
    bit [7:0]  led0 = 0;

    initial begin
        int          cyc;
        logic [31:0] rd;
        bit          er;

        sw_in = 8'h3C;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_led", 32'(led_out), 0);
        chk("rst_led0", 32'(led_out0), 0);
        #2 reset = 1;
        @(negedge clk);

        txn(0, 0, 32'h10, 0, 0, cyc, rd, er);
        chk("rd10_cycles", 32'(cyc), 3);
        chk("rd10_data", rd, 32'h0);
        chk("rd10_err", 32'(er), 0);
        @(negedge clk);
        chk("ready_width", 32'(ready), 0);

        txn(0, 1, 32'h40, 32'h1234_5678, 1, cyc, rd, er);
        chk("wr40_cycles", 32'(cyc), 3);
        txn(0, 0, 32'h40, 0, 0, cyc, rd, er);
        chk("b2b_cycles", 32'(cyc), 4);
        chk("raw_data", rd, 32'h1234_5678);

        @(negedge clk);
        txn(0, 1, LED_A, 32'h0000_00A5, 0, cyc, rd, er);
        @(negedge clk);
        chk("led_a5", 32'(led_out), 32'hA5);
        txn(0, 0, SW_A, 0, 0, cyc, rd, er);
        chk("sw_read", rd, 32'h3C);

        @(negedge clk);
        txn(0, 0, 32'h42, 0, 0, cyc, rd, er);
        chk("mis_cycles", 32'(cyc), 1);
        chk("mis_err", 32'(er), 1);
        chk("mis_data", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        txn(0, 0, 32'h0001_0000, 0, 0, cyc, rd, er);
        chk("oor_cycles", 32'(cyc), 1);
        chk("oor_err", 32'(er), 1);
        chk("oor_data", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        txn(0, 1, 32'h41, 32'h7777_7777, 0, cyc, rd, er);
        chk("errwr_err", 32'(er), 1);
        txn(0, 0, 32'h40, 0, 0, cyc, rd, er);
        chk("errwr_kept", rd, 32'h1234_5678);

        // Bus changes after acceptance must not leak into the transaction.
        @(negedge clk);
        req = 1; we = 1; addr = 32'h80; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        addr = 32'h84; wdata = 32'h0BAD_0BAD; we = 0;
        wait_ready(0, cyc);
        req = 0;
        txn(0, 0, 32'h80, 0, 0, cyc, rd, er);
        chk("cap_80", rd, 32'hFFFF_FFFF);
        txn(0, 0, 32'h84, 0, 0, cyc, rd, er);
        chk("cap_84", rd, 32'h0);

        // Reset while the write is waiting.
        @(negedge clk);
        req = 1; we = 1; addr = 32'h80; wdata = 32'h0000_0055;
        @(negedge clk);
        #2 reset = 0; req = 0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_led", 32'(led_out), 0);
        #2 reset = 1;
        @(negedge clk);
        txn(0, 0, 32'h80, 0, 0, cyc, rd, er);
        chk("abort_kept", rd, 32'hFFFF_FFFF);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 150; i++) begin
            int unsigned k, idx;
            logic [31:0] a;
            bit hold;
            k = $urandom_range(0, 9);
            idx = ($urandom_range(0, 7) == 0) ? $urandom_range(500, 511) : $urandom_range(0, 15);
            if (k <= 5) a = idx * 4;
            else if (k == 6) a = LED_A;
            else if (k == 7) a = SW_A;
            else if (k == 8) a = idx * 4 + $urandom_range(1, 3);
            else a = ($urandom_range(0, 1) != 0) ? 32'h0001_0000 + idx * 4 : 32'h8000_0000;
            hold = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom);
            txn(0, ($urandom_range(0, 1) != 0), a, $urandom, hold, cyc, rd, er);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req = 0;
        repeat (4) @(negedge clk);

        // Zero-latency instance: every response lands one cycle after accept.
        for (int i = 0; i < 40; i++) begin
            int unsigned k, idx;
            logic [31:0] a, d;
            bit w, e;
            k = $urandom_range(0, 4);
            idx = $urandom_range(0, 7);
            w = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : ($urandom_range(0, 1) != 0);
            if (i < 2) begin k = 0; idx = 16; end
            d = $urandom;
            if (k == 4) a = LED_A;
            else if (k == 3) a = idx * 4 + 1;
            else a = idx * 4;
            e = (k == 3);
            txn(1, w, a, d, 0, cyc, rd, er);
            chk("l0_cycles", 32'(cyc), 1);
            chk("l0_err", 32'(er), 32'(e));
            if (!w) begin
                if (e) chk("l0_rdata", rd, 32'hDEAD_BEEF);
                else if (k == 4) chk("l0_rdata", rd, {24'b0, led0});
                else chk("l0_rdata", rd, mem0[idx]);
            end else if (!e) begin
                if (k == 4) led0 = d[7:0];
                else mem0[idx] = d;
            end
            @(negedge clk);
            chk("l0_led", 32'(led_out0), 32'(led0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
